es_hilo_div: RTL

Execute-stage HI/LO unit: receives the decoded `div_sel`, `mul_sel`, `mthi`/`mtlo`/`mfhi`/`mflo` and operand fields that the decode stage places on the DS→ES bus. It runs a 32-iteration restoring divider for DIV/DIVU and owns the architectural HI/LO registers. It commits HI/LO when the owning instruction leaves EX, and returns `ready_go` so the execute stage stalls while a divide is in flight. MULT/MULTU products arrive precomputed from decode; this block only commits them.

---
 rtl/es_hilo_div.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/es_hilo_div.sv
// es_hilo_div: execute-stage HI/LO unit with a restoring divider.
// Owns HI/LO and stalls EX via ready_go while a divide is in flight.
module es_hilo_div #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_valid,
    input  logic        es_fire,
    input  logic [1:0]  div_sel,
    input  logic        mul_sel,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic        mfhi,
    input  logic        mflo,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic        ready_go,
    output logic [31:0] hilo_rdata,
    output logic [31:0] hi_q,
    output logic [31:0] lo_q
);

    localparam int CW = $clog2(DIV_ITER + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   dvsr_q, dvsr_d;
    logic          sgn_q, sgn_d;
    logic          neg1_q, neg1_d;
    logic          neg2_q, neg2_d;
    logic [31:0]   hi_d, lo_d;

    logic          div_req;
    logic          last_step;
    logic          wr_en;
    logic [63:0]   shl;
    logic [32:0]   diff;
    logic [63:0]   step;
    logic [31:0]   quo_fix, rem_fix;

    assign div_req   = es_valid & (|div_sel);
    assign last_step = (cnt_q == CW'(DIV_ITER - 1));

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; losing the EX instruction always aborts
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (div_req) state_d = S_BUSY;
            S_BUSY:  if (last_step) state_d = S_DONE;
            S_DONE:  if (es_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (!es_valid) state_d = S_IDLE;
    end

    // FSM outputs: stall, HI/LO commit selection, MFHI/MFLO read
    always_comb begin
        ready_go = ~div_req | (state_q == S_DONE);
        wr_en    = es_fire & ready_go;
        hi_d     = hi_q;
        lo_d     = lo_q;
        if (wr_en) begin
            if ((state_q == S_DONE) && div_req) begin
                hi_d = acc_q[63:32];
                lo_d = acc_q[31:0];
            end else if (mul_sel) begin
                hi_d = mul_hi;
                lo_d = mul_lo;
            end else if (mthi) begin
                hi_d = src1;
            end else if (mtlo) begin
                lo_d = src1;
            end
        end
        if (mfhi)      hilo_rdata = hi_q;
        else if (mflo) hilo_rdata = lo_q;
        else           hilo_rdata = 32'h0;
    end

    // One restoring step, plus the sign fix used on the final step
    always_comb begin
        shl     = {acc_q[62:0], 1'b0};
        diff    = {1'b0, shl[63:32]} - {1'b0, dvsr_q};
        step    = diff[32] ? shl : {diff[31:0], shl[31:1], 1'b1};
        quo_fix = (sgn_q & (neg1_q ^ neg2_q)) ? -step[31:0] : step[31:0];
        rem_fix = (sgn_q & neg1_q) ? -step[63:32] : step[63:32];
    end

    // Divider datapath next state: load magnitudes, iterate, hold
    always_comb begin
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        dvsr_d = dvsr_q;
        sgn_d  = sgn_q;
        neg1_d = neg1_q;
        neg2_d = neg2_q;
        unique case (state_q)
            S_IDLE: begin
                if (div_req) begin
                    sgn_d  = div_sel[1];
                    neg1_d = div_sel[1] & src1[31];
                    neg2_d = div_sel[1] & src2[31];
                    acc_d  = {32'h0, (div_sel[1] & src1[31]) ? -src1 : src1};
                    dvsr_d = (div_sel[1] & src2[31]) ? -src2 : src2;
                    cnt_d  = '0;
                end
            end
            S_BUSY: begin
                acc_d = last_step ? {rem_fix, quo_fix} : step;
                cnt_d = cnt_q + CW'(1);
            end
            default: ;
        endcase
    end

    // Divider datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            dvsr_q <= '0;
            sgn_q  <= 1'b0;
            neg1_q <= 1'b0;
            neg2_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            dvsr_q <= dvsr_d;
            sgn_q  <= sgn_d;
            neg1_q <= neg1_d;
            neg2_q <= neg2_d;
        end
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule
